// File: rtl/cfu_rsp_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cfu_rsp_buffer
// Description : CFU command/response buffer. Registers each accepted command
//               onto a one-cycle RAM strobe, captures the RAM result a cycle
//               later into a response FIFO and returns results in order.
// Revision    : 1.0 - initial release
// ============================================================================
module cfu_rsp_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        mem_valid,
    output logic [9:0]  mem_function_id,
    output logic [31:0] mem_inputs_0,
    output logic [31:0] mem_inputs_1,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  occupancy
);

    localparam int                c_AW      = $clog2(DEPTH);
    localparam int                c_CW      = c_AW + 1;
    localparam logic [c_CW-1:0]   c_FULL    = c_CW'(DEPTH);
    localparam logic [4:0]        c_OCC_MAX = 5'(DEPTH);

    generate
        if (!(DEPTH == 2 || DEPTH == 4 || DEPTH == 8 || DEPTH == 16)) begin : g_depth_check
            $error("cfu_rsp_buffer: DEPTH must be 2, 4, 8 or 16");
        end
    endgenerate

    logic              r_live;
    logic              r_mem_valid;
    logic [9:0]        r_mem_fid;
    logic [31:0]       r_mem_in0;
    logic [31:0]       r_mem_in1;
    logic              r_wr_pend;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_fifo_cnt;
    logic [4:0]        r_occ;
    logic [31:0]       r_fifo [DEPTH];

    logic              w_accept;
    logic              w_pop;

    // r_live keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready             = r_live && (r_occ < c_OCC_MAX);
    assign rsp_valid             = (r_fifo_cnt != '0);
    assign rsp_payload_outputs_0 = rsp_valid ? r_fifo[r_rd_ptr] : 32'h0;
    assign mem_valid             = r_mem_valid;
    assign mem_function_id       = r_mem_fid;
    assign mem_inputs_0          = r_mem_in0;
    assign mem_inputs_1          = r_mem_in1;
    assign occupancy             = r_occ;

    assign w_accept = cmd_valid && cmd_ready;
    assign w_pop    = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_live      <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_fid   <= '0;
            r_mem_in0   <= '0;
            r_mem_in1   <= '0;
            r_wr_pend   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            r_occ       <= '0;
        end else begin
            r_live      <= 1'b1;
            r_mem_valid <= w_accept;
            if (w_accept) begin
                r_mem_fid <= cmd_payload_function_id;
                r_mem_in0 <= cmd_payload_inputs_0;
                r_mem_in1 <= cmd_payload_inputs_1;
            end
            // mem_rdata is valid in the cycle after the strobe.
            r_wr_pend <= r_mem_valid;
            if (r_wr_pend) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({r_wr_pend, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_occ <= r_occ + 5'd1;
                2'b01:   r_occ <= r_occ - 5'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage is not reset; entries are only visible through rsp_valid.
    always_ff @(posedge clk) begin
        if (r_wr_pend) begin
            r_fifo[r_wr_ptr] <= mem_rdata;
        end
    end

    // Occupancy bounds in-flight plus queued entries, so this cannot fire.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(r_wr_pend && (r_fifo_cnt == c_FULL)));

endmodule
`default_nettype wire

// File: doc/cfu_rsp_buffer.md
CFU_RSP_BUFFER -- requirements
Module: cfu_rsp_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning response FIFO entries and max outstanding commands; legal values 2, 4, 8, 16.
REQ-002 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port cmd_valid  in  1  CPU command valid.
REQ-005 Port cmd_ready  out  1  buffer can accept a command.
REQ-006 Port cmd_payload_function_id  in  10  CPU function id.
REQ-007 Port cmd_payload_inputs_0  in  32  CPU operand 0.
REQ-008 Port cmd_payload_inputs_1  in  32  CPU operand 1.
REQ-009 Port rsp_valid  out  1  response available to CPU.
REQ-010 Port rsp_ready  in  1  CPU takes response.
REQ-011 Port rsp_payload_outputs_0  out  32  response data.
REQ-012 Port mem_valid  out  1  one-cycle access strobe to the downstream RAM stage.
REQ-013 Port mem_function_id  out  10  registered function id.
REQ-014 Port mem_inputs_0  out  32  registered operand 0.
REQ-015 Port mem_inputs_1  out  32  registered operand 1.
REQ-016 Port mem_rdata  in  32  RAM stage result, valid exactly one cycle after mem_valid.
REQ-017 Port occupancy  out  5  outstanding commands (issued, in flight, or queued), 0..DEPTH.

Function
REQ-018 Accept occurs when cmd_valid and cmd_ready are both 1 at a rising edge.
REQ-019 cmd_ready SHALL be 1 exactly when occupancy < DEPTH, combinational from registered state only; it does not depend on cmd_valid or rsp_ready.
REQ-020 On accept at edge T, mem_valid SHALL be 1 during the following cycle with mem_* holding the accepted payload; otherwise mem_valid SHALL be 0.
REQ-021 mem_* payload registers SHALL hold their last values while mem_valid is 0.
REQ-022 The cycle after mem_valid=1, mem_rdata SHALL be written into the FIFO tail at that cycle's closing edge; no other FIFO writes occur.
REQ-023 Fixed latency: with rsp_ready=1 and an empty FIFO, rsp_valid SHALL rise 3 cycles after the accept edge.
REQ-024 rsp_valid SHALL equal FIFO not-empty; rsp_payload_outputs_0 SHALL be the FIFO head entry, registered, stable while rsp_valid=1 and rsp_ready=0.
REQ-025 Pop occurs when rsp_valid and rsp_ready are both 1 at a rising edge.
REQ-026 Responses SHALL leave in accept order; no reordering, loss, or duplication.
REQ-027 Occupancy +1 on accept, -1 on pop, unchanged when both occur at the same edge.
REQ-028 FIFO write and pop at the same edge SHALL both take effect, including when the FIFO is empty and when it is full.
REQ-029 FIFO pointers are log2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-030 Overflow is impossible by construction; a FIFO write while FIFO count = DEPTH SHALL be treated as a design error and flagged by an assertion.
REQ-031 rsp_payload_outputs_0 SHALL read 32'h0 whenever rsp_valid=0.

Reset
REQ-032 While reset=0: cmd_ready=0, mem_valid=0, mem_* payload=0, rsp_valid=0, rsp_payload_outputs_0=0, occupancy=0, FIFO pointers=0.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight and queued responses immediately; no response from before reset SHALL ever appear.
REQ-034 cmd_ready SHALL first be 1 in the first cycle after reset deasserts.

Verification
REQ-035 Single command: accept fn=1, in0=5, in1=9, mem_rdata=32'hA5A5_0001, rsp_ready=1 -> mem_valid for 1 cycle with payload 1/5/9; rsp_valid 3 cycles after accept with 32'hA5A5_0001.
REQ-036 Backpressure fill, DEPTH=4, rsp_ready=0: issue 6 back-to-back commands -> exactly 4 accepted, cmd_ready=0 from the edge after the 4th accept, occupancy=4.
REQ-037 Drain from full: raise rsp_ready -> 4 responses in accept order; cmd_ready=1 the cycle after the first pop.
REQ-038 Streaming: cmd_valid=1 and rsp_ready=1 for 20 cycles -> 1 accept and 1 pop per cycle in steady state; occupancy constant at 3; pointers wrap without data error.
REQ-039 Reset mid-flight: 3 commands outstanding, reset=0 for 1 cycle -> all outputs at reset values; after release, a new command returns only its own data.
REQ-040 Simultaneous: occupancy=DEPTH-1 with accept and pop at the same edge -> occupancy unchanged and cmd_ready stays 1.
